// File: rtl/ct_cross_arbiter.sv
// ---------------------------------------------------------------------------
// ct_cross_arbiter
//
// Round-robin, packet-aware arbiter that funnels NI requester streams into
// the single write port of a clock-crossing FIFO. One requester wins per
// packet (or per beat). Its beat is registered and tagged with the source
// index, so the far side of the crossing can demultiplex it.
//
// Configuration macro:
//   CT_ARB_PKT_LOCK_EN  defined   : the winner keeps the channel until its
//                                   end-of-packet beat (packet lock).
//                       undefined : per-beat round-robin. i_eop is still
//                                   forwarded to o_eop.
//
// Parameters:
//   NI     number of requesters (2..16)
//   WIDTH  payload width per beat
//   SW     source-index width, derived as $clog2(NI)
//
// Ports:
//   clk      in   crossing FIFO write clock
//   arst     in   asynchronous active-high reset
//   i_data   in   NI*WIDTH  requester payloads, requester k at [k*WIDTH +: WIDTH]
//   i_valid  in   NI        per-requester beat valid
//   i_eop    in   NI        per-requester end-of-packet, qualified by i_valid
//   o_ready  out  NI        per-requester accept, at most one bit high
//   o_data   out  WIDTH     registered winning payload
//   o_eop    out  1         registered end-of-packet flag
//   o_src    out  SW        registered source index of o_data
//   o_valid  out  1         output beat valid
//   i_ready  in   1         downstream (crossing FIFO) accept
// ---------------------------------------------------------------------------
module ct_cross_arbiter #(
    parameter  int NI    = 4,
    parameter  int WIDTH = 32,
    localparam int SW    = $clog2(NI)
) (
    input  logic                clk,
    input  logic                arst,
    input  logic [NI*WIDTH-1:0] i_data,
    input  logic [NI-1:0]       i_valid,
    input  logic [NI-1:0]       i_eop,
    output logic [NI-1:0]       o_ready,
    output logic [WIDTH-1:0]    o_data,
    output logic                o_eop,
    output logic [SW-1:0]       o_src,
    output logic                o_valid,
    input  logic                i_ready
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_run;
    logic [SW-1:0]    r_last;
    logic [SW-1:0]    r_owner;
    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic             r_eop;
    logic [SW-1:0]    r_src;

    logic             w_ld;
    logic             w_rr_found;
    logic [SW-1:0]    w_rr_sel;
    logic [SW-1:0]    w_sel;
    logic             w_xfer;
    logic             w_sel_eop;
    logic [WIDTH-1:0] w_sel_data;

    // The output register may load when it is empty or is being drained this cycle.
    assign w_ld = r_run & (i_ready | ~r_valid);

    // Rotating search starting just after the last packet winner, so the
    // requester that finished most recently has the lowest priority.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch;
        // a path that leaves a signal unassigned would infer a latch.
        w_rr_found = 1'b0;
        w_rr_sel   = '0;
        for (int i = 1; i <= NI; i++) begin
            logic [SW:0] w_cand;
            w_cand = {1'b0, r_last} + (SW+1)'(i);
            if (w_cand >= (SW+1)'(NI)) begin
                w_cand = w_cand - (SW+1)'(NI);
            end
            if (!w_rr_found && i_valid[w_cand[SW-1:0]]) begin
                w_rr_found = 1'b1;
                w_rr_sel   = w_cand[SW-1:0];
            end
        end
    end

    assign w_sel = (r_state == ST_LOCK) ? r_owner : w_rr_sel;

    // In LOCK only the owner is offered the slot. If the owner stalls, the
    // cycle is a bubble and no other requester is considered.
    always_comb begin
        o_ready = '0;
        if (r_state == ST_LOCK) begin
            o_ready[r_owner] = w_ld;
        end else if (w_rr_found) begin
            o_ready[w_rr_sel] = w_ld;
        end
    end

    assign w_xfer     = |(o_ready & i_valid);
    assign w_sel_eop  = i_eop[w_sel];
    assign w_sel_data = i_data[w_sel*WIDTH +: WIDTH];

    // Next-state logic. Without packet lock the FSM never leaves IDLE.
    always_comb begin
        w_state_nxt = r_state;
`ifdef CT_ARB_PKT_LOCK_EN
        if (w_xfer) begin
            case (r_state)
                ST_IDLE: if (!w_sel_eop) w_state_nxt = ST_LOCK;
                ST_LOCK: if (w_sel_eop)  w_state_nxt = ST_IDLE;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values regardless of the order of statements.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: the payload register is reset as well as the control flops,
    // because its reset value is visible on o_data/o_src before the first beat.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_run   <= 1'b0;
            r_last  <= SW'(NI-1);
            r_owner <= '0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_eop   <= 1'b0;
            r_src   <= '0;
        end else begin
            r_run <= 1'b1;
            if (w_ld) begin
                if (w_xfer) begin
                    r_valid <= 1'b1;
                    r_data  <= w_sel_data;
                    r_eop   <= w_sel_eop;
                    r_src   <= w_sel;
                end else begin
                    // Drained with nothing to replace it; the payload keeps its last value.
                    r_valid <= 1'b0;
                end
            end
`ifdef CT_ARB_PKT_LOCK_EN
            if (w_xfer && r_state == ST_IDLE && !w_sel_eop) begin
                r_owner <= w_sel;
            end
            if (w_xfer && w_sel_eop) begin
                r_last <= w_sel;
            end
`else
            if (w_xfer) begin
                r_last <= w_sel;
            end
`endif
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_eop   = r_eop;
    assign o_src   = r_src;

endmodule

// File: tb/tb_ct_cross_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ct_cross_arbiter
//
// Self-checking bench for ct_cross_arbiter (NI=4, WIDTH=32). Each requester
// has a queue of beats that is presented on its port and popped when the
// beat is accepted. Expected output beats are pushed to a scoreboard in the
// order the arbitration rules dictate. They are popped and compared whenever
// the DUT hands a beat downstream. The packet-lock expectations follow
// CT_ARB_PKT_LOCK_EN.
// ---------------------------------------------------------------------------
module tb_ct_cross_arbiter;

    localparam int NI    = 4;
    localparam int WIDTH = 32;
    localparam int SW    = 2;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             eop;
        logic [SW-1:0]    src;
    } beat_t;

    logic                clk = 1'b0;
    logic                arst;
    logic [NI*WIDTH-1:0] i_data;
    logic [NI-1:0]       i_valid;
    logic [NI-1:0]       i_eop;
    logic [NI-1:0]       o_ready;
    logic [WIDTH-1:0]    o_data;
    logic                o_eop;
    logic [SW-1:0]       o_src;
    logic                o_valid;
    logic                i_ready;

    beat_t       src_q[NI][$];
    beat_t       exp_q[$];
    logic [NI-1:0] en;
    int          n_tests = 0;
    int          n_fail  = 0;

    ct_cross_arbiter #(.NI(NI), .WIDTH(WIDTH)) u_dut (
        .clk     (clk),
        .arst    (arst),
        .i_data  (i_data),
        .i_valid (i_valid),
        .i_eop   (i_eop),
        .o_ready (o_ready),
        .o_data  (o_data),
        .o_eop   (o_eop),
        .o_src   (o_src),
        .o_valid (o_valid),
        .i_ready (i_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic beat_t mk(input int k, input int p, input int b, input bit eop);
        beat_t t;
        t.data = {8'(k + 1), 8'(p), 16'(b)};
        t.eop  = eop;
        t.src  = SW'(k);
        return t;
    endfunction

    task automatic push_pkt(input int k, input int p, input int len);
        for (int b = 0; b < len; b++) src_q[k].push_back(mk(k, p, b, b == len - 1));
    endtask

    task automatic expect_beat(input int k, input int p, input int b, input bit eop);
        exp_q.push_back(mk(k, p, b, eop));
    endtask

    task automatic expect_pkt(input int k, input int p, input int len);
        for (int b = 0; b < len; b++) expect_beat(k, p, b, b == len - 1);
    endtask

    task automatic drive();
        i_valid = '0;
        i_eop   = '0;
        i_data  = '0;
        for (int k = 0; k < NI; k++) begin
            if (en[k] && src_q[k].size() > 0) begin
                i_valid[k]                = 1'b1;
                i_eop[k]                  = src_q[k][0].eop;
                i_data[k*WIDTH +: WIDTH]  = src_q[k][0].data;
            end
        end
    endtask

    // One clock: monitor at the falling edge, then retire accepted beats and
    // re-drive just after the rising edge.
    task automatic cycle();
        logic [NI-1:0] acc;
        beat_t         e;
        @(negedge clk);
        acc = o_ready & i_valid;
        if (!arst) begin
            check("ready_onehot", 64'($onehot0(o_ready)), 64'(1));
            if (o_valid && i_ready) begin
                check("exp_avail", 64'(exp_q.size() > 0), 64'(1));
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("out_beat", 64'({o_data, o_eop, o_src}), 64'(e));
                end
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) begin
            if (acc[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
        end
        drive();
        #1;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int c = 0;
        int left = 0;
        while (exp_q.size() > 0 && c < budget) begin
            cycle();
            c++;
        end
        check({tag, "_drain"}, 64'(exp_q.size()), 64'(0));
        for (int k = 0; k < NI; k++) left += src_q[k].size();
        check({tag, "_src_empty"}, 64'(left), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        arst    = 1'b1;
        i_ready = 1'b1;
        en      = '1;
        i_valid = '0;
        i_eop   = '0;
        i_data  = '0;

        // ---- reset release + round robin: 2 single-beat packets per requester
        for (int p = 0; p < 2; p++)
            for (int k = 0; k < NI; k++) begin
                push_pkt(k, p, 1);
                expect_pkt(k, p, 1);
            end
        drive();
        #12;
        check("rst_valid", 64'(o_valid), 64'(0));
        check("rst_data",  64'(o_data),  64'(0));
        check("rst_eop",   64'(o_eop),   64'(0));
        check("rst_src",   64'(o_src),   64'(0));
        check("rst_ready", 64'(o_ready), 64'(0));
        #10 arst = 1'b0;
        #1;
        check("ready_before_run", 64'(o_ready), 64'(0));
        @(posedge clk);
        #1;
        check("first_grant", 64'(o_ready), 64'(4'b0001));
        check("valid_before_accept", 64'(o_valid), 64'(0));
        cycle();
        check("valid_after_accept", 64'(o_valid), 64'(1));
        check("first_src", 64'(o_src), 64'(0));
        for (int i = 0; i < 2 * NI; i++) begin
            check("rr_nogap", 64'(o_valid), 64'(1));
            cycle();
        end
        wait_drain("rr", 4);

        // ---- backpressure
        for (int k = 0; k < NI; k++) begin
            push_pkt(k, 2, 1);
            expect_pkt(k, 2, 1);
        end
        drive();
        #1;
        cycle();
        i_ready = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            check("bp_ready", 64'(o_ready), 64'(0));
            check("bp_valid", 64'(o_valid), 64'(1));
            check("bp_src",   64'(o_src),   64'(0));
            check("bp_data",  64'(o_data),  64'(mk(0, 2, 0, 1'b1).data));
            cycle();
        end
        i_ready = 1'b1;
        #1;
        wait_drain("bp", 20);

        // ---- multi-beat packets from req1 (3 beats) and req2 (2 beats)
        push_pkt(1, 3, 3);
        push_pkt(2, 3, 2);
`ifdef CT_ARB_PKT_LOCK_EN
        expect_pkt(1, 3, 3);
        expect_pkt(2, 3, 2);
`else
        expect_beat(1, 3, 0, 1'b0);
        expect_beat(2, 3, 0, 1'b0);
        expect_beat(1, 3, 1, 1'b0);
        expect_beat(2, 3, 1, 1'b1);
        expect_beat(1, 3, 2, 1'b1);
`endif
        drive();
        #1;
`ifdef CT_ARB_PKT_LOCK_EN
        for (int i = 0; i < 10 && src_q[1].size() > 0; i++) begin
            check("lock_ready2", 64'(o_ready[2]), 64'(0));
            cycle();
        end
`endif
        wait_drain("pkt", 30);

        // ---- owner bubble: req3 4-beat packet, stalls 2 cycles after beat 1
        push_pkt(3, 4, 4);
        expect_pkt(3, 4, 4);
`ifdef CT_ARB_PKT_LOCK_EN
        push_pkt(0, 4, 2);
        expect_pkt(0, 4, 2);
`endif
        drive();
        #1;
        cycle();
        cycle();
        en[3] = 1'b0;
        drive();
        #1;
        for (int i = 0; i < 2; i++) begin
            cycle();
            check("bubble_valid", 64'(o_valid), 64'(0));
`ifdef CT_ARB_PKT_LOCK_EN
            check("bubble_ready0", 64'(o_ready[0]), 64'(0));
`endif
        end
        en[3] = 1'b1;
        drive();
        #1;
        cycle();
        check("bubble_resume_valid", 64'(o_valid), 64'(1));
        check("bubble_resume_src",   64'(o_src),   64'(3));
        wait_drain("bubble", 20);

        // ---- reset during beat 2 of a 4-beat packet
        push_pkt(1, 5, 4);
        expect_beat(1, 5, 0, 1'b0);
        drive();
        #1;
        cycle();
        cycle();
        check("pre_rst_src", 64'(o_src), 64'(1));
        check("pre_rst_exp", 64'(exp_q.size()), 64'(0));
        #1 arst = 1'b1;
        #1;
        check("mid_rst_valid", 64'(o_valid), 64'(0));
        check("mid_rst_ready", 64'(o_ready), 64'(0));
        check("mid_rst_src",   64'(o_src),   64'(0));
        for (int k = 0; k < NI; k++) src_q[k].delete();
        exp_q.delete();
        for (int k = 0; k < 3; k++) begin
            push_pkt(k, 6, 1);
            expect_pkt(k, 6, 1);
        end
        drive();
        @(posedge clk);
        @(negedge clk);
        #2 arst = 1'b0;
        #1;
        check("rst2_ready_before_run", 64'(o_ready), 64'(0));
        @(posedge clk);
        #1;
        check("rst2_grant", 64'(o_ready), 64'(4'b0001));
        wait_drain("rst2", 20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
